hazard_ctrl: RTL and testbench

Pipeline interlock controller for the 16-bit five-stage core (IF, ID, EX, MEM, WB). It sits beside the decode stage and watches the decoded register reads and writes, loads, branches, jumps and halts. It tracks in-flight destination registers in a three-slot shadow pipeline. From that state it drives stall, bubble and flush controls for the stage registers, and it sequences the end-of-program halt drain.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_scoreboard.sv | 50 +++++
 rtl/hazard_ctrl.sv | 110 +++++++++++
 tb/tb_hazard_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline interlock controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] reg_addr;
        logic       is_load;
    } slot_t;

    localparam logic [3:0] R0    = 4'd0;
    localparam int         CNT_W = 16;

    // R0 is hardwired to zero, so it can never carry a dependency.
    function automatic logic src_match(input logic en, input logic [3:0] src, input slot_t s);
        return en && s.valid && (src != R0) && (src == s.reg_addr);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot shadow pipeline of in-flight destinations and the RAW match logic.
// HAZARD_FWD_EN: when defined, only a load sitting in EX causes a stall.
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rd_reg1,
    input  logic [3:0] rd_reg2,
    input  logic       rd_reg1_en,
    input  logic       rd_reg2_en,
    input  logic [3:0] wr_reg,
    input  logic       wr_reg_en,
    input  logic       mem_rd,
    input  logic       bubble,
    output logic       raw_stall
);

    slot_t ex_slot, mem_slot, wb_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_slot  <= '0;
            mem_slot <= '0;
            wb_slot  <= '0;
        end else begin
            ex_slot  <= bubble ? '0 : slot_t'{valid: wr_reg_en, reg_addr: wr_reg, is_load: mem_rd};
            mem_slot <= ex_slot;
            wb_slot  <= mem_slot;
        end
    end

    always_comb begin
        raw_stall = 1'b0;
`ifdef HAZARD_FWD_EN
        raw_stall = ex_slot.is_load &&
                    (src_match(rd_reg1_en, rd_reg1, ex_slot) ||
                     src_match(rd_reg2_en, rd_reg2, ex_slot));
`else
        // No bypassing anywhere: the value is unusable until WB has written it.
        raw_stall = src_match(rd_reg1_en, rd_reg1, ex_slot)  ||
                    src_match(rd_reg2_en, rd_reg2, ex_slot)  ||
                    src_match(rd_reg1_en, rd_reg1, mem_slot) ||
                    src_match(rd_reg2_en, rd_reg2, mem_slot) ||
                    src_match(rd_reg1_en, rd_reg1, wb_slot)  ||
                    src_match(rd_reg2_en, rd_reg2, wb_slot);
`endif
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock controller: stall/bubble/flush priority, halt drain FSM, stall counter.
// HAZARD_FWD_EN selects the forwarding-aware RAW rule inside hazard_scoreboard.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DRAIN_CYC = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [3:0]       i_rdReg1,
    input  logic [3:0]       i_rdReg2,
    input  logic             i_rdReg1En,
    input  logic             i_rdReg2En,
    input  logic [3:0]       i_wrReg,
    input  logic             i_wrRegEn,
    input  logic             i_memRd,
    input  logic             i_sawJ,
    input  logic             i_hlt,
    input  logic             i_brTaken,
    output logic             o_stallIF,
    output logic             o_bubbleEX,
    output logic             o_flushID,
    output logic             o_hlt,
    output logic [CNT_W-1:0] o_stallCnt
);

    state_t           state, state_next;
    logic [7:0]       drain_cnt, drain_cnt_next;
    logic [CNT_W-1:0] stall_cnt;
    logic             raw_stall;

    hazard_scoreboard u_scoreboard (
        .clk        (i_clk),
        .rst        (i_rst),
        .rd_reg1    (i_rdReg1),
        .rd_reg2    (i_rdReg2),
        .rd_reg1_en (i_rdReg1En),
        .rd_reg2_en (i_rdReg2En),
        .wr_reg     (i_wrReg),
        .wr_reg_en  (i_wrRegEn),
        .mem_rd     (i_memRd),
        .bubble     (o_bubbleEX),
        .raw_stall  (raw_stall)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
        end
    end

    // Priority: taken branch > RAW stall > jump/halt. The acceptance edge counts as
    // the first drain cycle, so HALTED is reached DRAIN_CYC cycles after acceptance.
    always_comb begin
        o_stallIF      = 1'b0;
        o_bubbleEX     = 1'b0;
        o_flushID      = 1'b0;
        state_next     = state;
        drain_cnt_next = drain_cnt;
        case (state)
            RUN: begin
                if (i_brTaken) begin
                    o_flushID  = 1'b1;
                    o_bubbleEX = 1'b1;
                end else if (raw_stall) begin
                    o_stallIF  = 1'b1;
                    o_bubbleEX = 1'b1;
                end else begin
                    o_flushID = i_sawJ;
                    if (i_hlt) begin
                        drain_cnt_next = 8'(DRAIN_CYC - 1);
                        if (DRAIN_CYC <= 1)
                            state_next = HALTED;
                        else
                            state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                o_stallIF      = 1'b1;
                o_flushID      = 1'b1;
                o_bubbleEX     = i_brTaken | raw_stall;
                drain_cnt_next = drain_cnt - 8'd1;
                if (drain_cnt <= 8'd1)
                    state_next = HALTED;
            end
            HALTED: begin
                o_stallIF  = 1'b1;
                o_flushID  = 1'b1;
                o_bubbleEX = i_brTaken | raw_stall;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            stall_cnt <= '0;
        else if (raw_stall && (state != HALTED) && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign o_hlt      = (state == HALTED);
    assign o_stallCnt = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed table, multi-cycle sequences, random vs. model.
// Expected values follow HAZARD_FWD_EN when the same macro is defined for the bench.
module tb_hazard_ctrl;

    localparam int DRAIN_CYC = 3;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [3:0] rd1;
        logic       rd1_en;
        logic [3:0] rd2;
        logic       rd2_en;
        logic [3:0] wr;
        logic       wr_en;
        logic       mem_rd;
        logic       saw_j;
        logic       hlt;
        logic       br;
    } in_t;

    typedef struct {
        in_t  in;
        logic stall;
        logic bubble;
        logic flush;
    } vec_t;

    typedef struct {
        bit valid;
        int dst;
        bit load;
    } issued_t;

    logic        clk, rst;
    logic [3:0]  rd_reg1, rd_reg2, wr_reg;
    logic        rd_reg1_en, rd_reg2_en, wr_reg_en, mem_rd, saw_j, hlt, br_taken;
    logic        stall_if, bubble_ex, flush_id, halted;
    logic [15:0] stall_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: what entered EX on each of the last three cycles (newest first).
    issued_t hist[$];
    bit      m_accepted;
    int      m_since;
    int      m_stalls;

    hazard_ctrl #(.DRAIN_CYC(DRAIN_CYC)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rdReg1   (rd_reg1),
        .i_rdReg2   (rd_reg2),
        .i_rdReg1En (rd_reg1_en),
        .i_rdReg2En (rd_reg2_en),
        .i_wrReg    (wr_reg),
        .i_wrRegEn  (wr_reg_en),
        .i_memRd    (mem_rd),
        .i_sawJ     (saw_j),
        .i_hlt      (hlt),
        .i_brTaken  (br_taken),
        .o_stallIF  (stall_if),
        .o_bubbleEX (bubble_ex),
        .o_flushID  (flush_id),
        .o_hlt      (halted),
        .o_stallCnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("[TB] FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1, "[TB] timeout");
    end

    function automatic in_t mk(int r1, bit e1, int r2, bit e2, int w, bit we, bit ld, bit j, bit h, bit b);
        in_t v;
        v.rd1 = 4'(r1); v.rd1_en = e1; v.rd2 = 4'(r2); v.rd2_en = e2;
        v.wr = 4'(w); v.wr_en = we; v.mem_rd = ld; v.saw_j = j; v.hlt = h; v.br = b;
        return v;
    endfunction

    function automatic bit model_raw(in_t v);
        int depth = FWD ? 1 : 3;
        for (int i = 0; i < depth && i < hist.size(); i++) begin
            if (hist[i].valid && hist[i].dst != 0 && (!FWD || hist[i].load) &&
                ((v.rd1_en && int'(v.rd1) == hist[i].dst) || (v.rd2_en && int'(v.rd2) == hist[i].dst)))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_accepted = 1'b0;
        m_since    = 0;
        m_stalls   = 0;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        rd_reg1 = v.rd1; rd_reg1_en = v.rd1_en; rd_reg2 = v.rd2; rd_reg2_en = v.rd2_en;
        wr_reg = v.wr; wr_reg_en = v.wr_en; mem_rd = v.mem_rd;
        saw_j = v.saw_j; hlt = v.hlt; br_taken = v.br;
    endtask

    // One cycle: drive after the falling edge, sample, then advance the model across the rising edge.
    task automatic applyStimulus(input string tag, input in_t v, input bit chk,
                                 output bit s, output bit b, output bit f);
        bit raw, es, eb, ef, eh;
        int ec;
        issued_t n;
        @(negedge clk);
        rst = 1'b0;
        drive(v);
        #1;
        raw = model_raw(v);
        eh  = m_accepted && (m_since >= DRAIN_CYC);
        if (m_accepted) begin
            es = 1'b1; ef = 1'b1; eb = raw | v.br;
        end else if (v.br) begin
            es = 1'b0; ef = 1'b1; eb = 1'b1;
        end else if (raw) begin
            es = 1'b1; ef = 1'b0; eb = 1'b1;
        end else begin
            es = 1'b0; eb = 1'b0; ef = v.saw_j;
        end
        ec = (m_stalls > 65535) ? 65535 : m_stalls;
        if (chk) begin
            checkOutput({tag, "_stallIF"},  int'(stall_if),  int'(es));
            checkOutput({tag, "_bubbleEX"}, int'(bubble_ex), int'(eb));
            checkOutput({tag, "_flushID"},  int'(flush_id),  int'(ef));
            checkOutput({tag, "_hlt"},      int'(halted),    int'(eh));
            checkOutput({tag, "_stallCnt"}, int'(stall_cnt), ec);
        end
        s = stall_if; b = bubble_ex; f = flush_id;
        n.valid = !eb && v.wr_en;
        n.dst   = int'(v.wr);
        n.load  = v.mem_rd;
        hist.push_front(n);
        if (hist.size() > 3) void'(hist.pop_back());
        if (raw && !eh) m_stalls++;
        if (m_accepted) m_since++;
        else if (v.hlt && !raw && !v.br) begin
            m_accepted = 1'b1;
            m_since    = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        model_reset();
    endtask

    initial begin
        vec_t tbl[12];
        in_t  idle, lw_r3, add_r3, alu_r3, sat;
        bit   s, b, f;
        int   n, first_hlt;

        idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lw_r3  = mk(0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
        add_r3 = mk(3, 1, 1, 1, 4, 1, 0, 0, 0, 0);
        alu_r3 = mk(1, 1, 2, 1, 3, 1, 0, 0, 0, 0);
        sat    = mk(1, 1, 1, 1, 1, 1, 1, 0, 0, 0);

        tbl[0]  = '{mk(1, 1, 2, 1, 4, 1, 0, 0, 0, 0), 0, 0, 0};
        tbl[1]  = '{mk(6, 1, 7, 1, 5, 1, 0, 0, 0, 0), 0, 0, 0};
        tbl[2]  = '{mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 0), 0, 0, 0};
        tbl[3]  = '{mk(0, 1, 0, 1, 6, 1, 0, 0, 0, 0), 0, 0, 0};
        tbl[4]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0, 0, 1};
        tbl[5]  = '{mk(2, 1, 0, 0, 3, 1, 1, 0, 0, 0), 0, 0, 0};
        tbl[6]  = '{mk(3, 1, 1, 1, 4, 1, 0, 0, 0, 1), 0, 1, 1};
        tbl[7]  = '{mk(8, 1, 3, 0, 9, 1, 0, 0, 0, 0), 0, 0, 0};
        tbl[8]  = '{mk(0, 0, 0, 0, 3, 1, 1, 0, 0, 0), 0, 0, 0};
        tbl[9]  = '{mk(1, 1, 3, 1, 4, 1, 0, 1, 0, 0), 1, 1, 0};
        tbl[10] = '{mk(0, 0, 3, 0, 0, 0, 0, 0, 1, 1), 0, 1, 1};
        tbl[11] = '{idle, 0, 0, 0};

        rst = 1'b1;
        drive(idle);
        model_reset();
        do_reset();
        applyStimulus("reset", idle, 1'b1, s, b, f);

        for (int i = 0; i < 12; i++) begin
            applyStimulus($sformatf("tbl%0d", i), tbl[i].in, 1'b1, s, b, f);
            checkOutput($sformatf("tbl%0d_vec_stall", i),  int'(s), int'(tbl[i].stall));
            checkOutput($sformatf("tbl%0d_vec_bubble", i), int'(b), int'(tbl[i].bubble));
            checkOutput($sformatf("tbl%0d_vec_flush", i),  int'(f), int'(tbl[i].flush));
        end

        // Load-use: consumer held in ID until the loaded value is reachable.
        do_reset();
        applyStimulus("lw", lw_r3, 1'b1, s, b, f);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus("lduse", add_r3, 1'b1, s, b, f);
            if (!s) break;
            n++;
        end
        checkOutput("loaduse_stall_cycles", n, FWD ? 1 : 3);
        checkOutput("loaduse_stallCnt", int'(stall_cnt), FWD ? 1 : 3);

        // ALU-use dependency.
        do_reset();
        applyStimulus("alu", alu_r3, 1'b1, s, b, f);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus("aluuse", mk(3, 1, 2, 1, 5, 1, 0, 0, 0, 0), 1'b1, s, b, f);
            if (!s) break;
            n++;
        end
        checkOutput("aluuse_stall_cycles", n, FWD ? 0 : 3);

        // Halt latency.
        do_reset();
        applyStimulus("hlt_acc", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1, s, b, f);
        first_hlt = -1;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus("drain", idle, 1'b1, s, b, f);
            if (halted && first_hlt < 0) first_hlt = k;
        end
        checkOutput("halt_latency", first_hlt, DRAIN_CYC);

        // Reset in the middle of DRAIN.
        do_reset();
        applyStimulus("hlt_acc2", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1, s, b, f);
        applyStimulus("drain2", idle, 1'b1, s, b, f);
        do_reset();
        applyStimulus("rst_drain", idle, 1'b1, s, b, f);
        checkOutput("rst_drain_ctrl", int'({stall_if, bubble_ex, flush_id, halted}), 0);

        // Reset in the middle of a stall; the dependent read must no longer match.
        do_reset();
        applyStimulus("lw2", lw_r3, 1'b1, s, b, f);
        applyStimulus("stall2", add_r3, 1'b1, s, b, f);
        do_reset();
        applyStimulus("rst_stall", add_r3, 1'b1, s, b, f);
        checkOutput("rst_stall_ctrl", int'({stall_if, bubble_ex, flush_id, halted}), 0);
        checkOutput("rst_stall_cnt", int'(stall_cnt), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            in_t v;
            v = mk($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0);
            applyStimulus("rand", v, 1'b1, s, b, f);
            if (halted && $urandom_range(0, 3) == 0) do_reset();
        end

        // Counter saturation under sustained load-use traffic.
        do_reset();
        for (int k = 0; k < 87400; k++)
            applyStimulus("sat", sat, 1'b0, s, b, f);
        checkOutput("sat_stallCnt", int'(stall_cnt), FWD ? 43700 : 65535);
        for (int k = 0; k < 8; k++)
            applyStimulus("sat_hold", sat, 1'b1, s, b, f);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
